// File: rtl/pipe_latch_skid_if.sv
// Handshake bundle for one pipeline-stage boundary.
// Handshake: a word moves upstream->stage when i_valid & o_ready are both high
// on a rising edge (and the stage is stepping); it moves stage->downstream when
// o_valid & i_ready are both high. Valid never waits on ready.
// master: the environment around the stage (drives i_*, consumes o_*).
// slave:  the stage itself.
interface pipe_latch_skid_if #(
    parameter int DATA_W = 64
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data
    );
endinterface

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage register with valid/ready handshake and optional 2-entry skid.
// The FSM state doubles as the live-entry count and is exposed on o_occupancy.
// With SKID_EN=1, o_ready depends only on registered state, so upstream stall
// logic has no combinational path from downstream ready.
module pipe_latch_skid #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter bit                SKID_EN   = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic             i_flush,
    pipe_latch_skid_if.slave bus,
    output logic [1:0]       o_occupancy,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    // Encoding equals the number of live entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_valid;
    logic w_ready;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_valid    = (r_state != ST_EMPTY);
    // Without the skid a full stage can only accept when it is draining the same cycle.
    assign w_ready    = SKID_EN ? (r_state != ST_SKID) : (bus.i_ready | ~w_valid);
    assign w_in_xfer  = bus.i_valid & w_ready & i_step;
    assign w_out_xfer = w_valid & bus.i_ready & i_step;

    assign bus.o_valid  = w_valid;
    assign bus.o_ready  = w_ready;
    assign bus.o_data   = r_data;
    assign o_occupancy  = r_state;
    assign o_stall_cnt  = r_stall_cnt;
    assign o_flush_cnt  = r_flush_cnt;

    // State, output register and skid register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data  <= FLUSH_VAL;
            r_skid  <= FLUSH_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Next-state and datapath selection; flush overrides any handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_data_nxt  = FLUSH_VAL;
            w_skid_nxt  = FLUSH_VAL;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_data_nxt  = bus.i_data;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_data_nxt = bus.i_data;
                    end else if (w_in_xfer) begin
                        // Only reachable with the skid present; o_ready is low otherwise.
                        if (SKID_EN) begin
                            w_state_nxt = ST_SKID;
                            w_skid_nxt  = bus.i_data;
                        end
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                        w_data_nxt  = FLUSH_VAL;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_data_nxt  = r_skid;
                        w_skid_nxt  = FLUSH_VAL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_data_nxt  = FLUSH_VAL;
                    w_skid_nxt  = FLUSH_VAL;
                end
            endcase
        end
    end

    // Saturating debug counters: stalled-with-data cycles and flush events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (i_step && w_valid && !bus.i_ready && !i_flush && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Bench for pipe_latch_skid: a skid instance (CNT_W=4, non-zero bubble) driven by a
// vector table, hand sequences and a random phase with an ordering scoreboard, plus
// a latch-only instance exercised by a short hand sequence.
module tb_pipe_latch_skid;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam logic [DW-1:0] FV_A = 16'hDEAD;
    localparam logic [DW-1:0] FV_B = 16'h0000;

    logic clk;
    logic rst;
    logic step_a, flush_a, step_b, flush_b;
    logic [1:0]    occ_a, occ_b;
    logic [CW-1:0] stall_a, stall_b, fcnt_a, fcnt_b;

    pipe_latch_skid_if #(.DATA_W(DW)) bus_a ();
    pipe_latch_skid_if #(.DATA_W(DW)) bus_b ();

    pipe_latch_skid #(.DATA_W(DW), .FLUSH_VAL(FV_A), .SKID_EN(1'b1), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .i_step(step_a), .i_flush(flush_a), .bus(bus_a),
        .o_occupancy(occ_a), .o_stall_cnt(stall_a), .o_flush_cnt(fcnt_a)
    );

    pipe_latch_skid #(.DATA_W(DW), .FLUSH_VAL(FV_B), .SKID_EN(1'b0), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .i_step(step_b), .i_flush(flush_b), .bus(bus_b),
        .o_occupancy(occ_b), .o_stall_cnt(stall_b), .o_flush_cnt(fcnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard: words accepted by dut_a, in order
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("sb_occ", 32'(occ_a), 32'(exp_q.size()));
            if (flush_a) begin
                exp_q.delete();
            end else begin
                if (bus_a.o_valid && bus_a.i_ready && step_a) begin
                    if (exp_q.size() == 0)
                        chk("sb_underflow", 32'(bus_a.o_data), 32'hFFFF_FFFF);
                    else
                        chk("sb_data", 32'(bus_a.o_data), 32'(exp_q.pop_front()));
                end
                if (bus_a.i_valid && bus_a.o_ready && step_a)
                    exp_q.push_back(bus_a.i_data);
            end
        end
    end

    // driver tasks
    task automatic drive_a(input logic st, input logic fl, input logic v,
                           input logic [DW-1:0] d, input logic r);
        step_a        = st;
        flush_a       = fl;
        bus_a.i_valid = v;
        bus_a.i_data  = d;
        bus_a.i_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic v, input logic r, input logic [DW-1:0] d,
                         input logic [1:0] o, input logic [CW-1:0] s, input logic [CW-1:0] f);
        chk({nm, "_valid"}, 32'(bus_a.o_valid), 32'(v));
        chk({nm, "_ready"}, 32'(bus_a.o_ready), 32'(r));
        chk({nm, "_data"},  32'(bus_a.o_data),  32'(d));
        chk({nm, "_occ"},   32'(occ_a),         32'(o));
        chk({nm, "_stall"}, 32'(stall_a),       32'(s));
        chk({nm, "_flush"}, 32'(fcnt_a),        32'(f));
    endtask

    typedef struct {
        logic          step;
        logic          flush;
        logic          valid;
        logic [DW-1:0] data;
        logic          ready;
        logic          ev;
        logic          er;
        logic [DW-1:0] ed;
        logic [1:0]    eo;
        logic [CW-1:0] es;
        logic [CW-1:0] ef;
    } vec_t;

    localparam int NV = 25;
    vec_t vt[NV];

    function automatic vec_t mk(logic st, logic fl, logic v, logic [DW-1:0] d, logic r,
                                logic ev, logic er, logic [DW-1:0] ed, logic [1:0] eo,
                                logic [CW-1:0] es, logic [CW-1:0] ef);
        vec_t x;
        x.step = st; x.flush = fl; x.valid = v; x.data = d; x.ready = r;
        x.ev = ev; x.er = er; x.ed = ed; x.eo = eo; x.es = es; x.ef = ef;
        return x;
    endfunction

    initial begin
        // inputs: step flush valid data ready ; expected after edge: valid ready data occ stall flushcnt
        // streaming
        vt[0]  = mk(1, 0, 1, 16'h10, 1,  1, 1, 16'h10, 1, 0, 0);
        vt[1]  = mk(1, 0, 1, 16'h11, 1,  1, 1, 16'h11, 1, 0, 0);
        vt[2]  = mk(1, 0, 1, 16'h12, 1,  1, 1, 16'h12, 1, 0, 0);
        vt[3]  = mk(1, 0, 0, 16'h00, 1,  0, 1, FV_A,   0, 0, 0);
        // backpressure into the skid, then drain
        vt[4]  = mk(1, 0, 1, 16'h0A, 0,  1, 1, 16'h0A, 1, 0, 0);
        vt[5]  = mk(1, 0, 1, 16'h0B, 0,  1, 0, 16'h0A, 2, 1, 0);
        vt[6]  = mk(1, 0, 0, 16'h00, 0,  1, 0, 16'h0A, 2, 2, 0);
        vt[7]  = mk(1, 0, 1, 16'h77, 0,  1, 0, 16'h0A, 2, 3, 0);
        vt[8]  = mk(1, 0, 0, 16'h00, 1,  1, 1, 16'h0B, 1, 3, 0);
        vt[9]  = mk(1, 0, 0, 16'h00, 1,  0, 1, FV_A,   0, 3, 0);
        // flush while in SKID with a same-cycle input
        vt[10] = mk(1, 0, 1, 16'h01, 0,  1, 1, 16'h01, 1, 3, 0);
        vt[11] = mk(1, 0, 1, 16'h02, 0,  1, 0, 16'h01, 2, 4, 0);
        vt[12] = mk(1, 1, 1, 16'h0C, 0,  0, 1, FV_A,   0, 4, 1);
        vt[13] = mk(1, 0, 0, 16'h00, 1,  0, 1, FV_A,   0, 4, 1);
        // debug freeze with valid and ready both high
        vt[14] = mk(1, 0, 1, 16'h20, 0,  1, 1, 16'h20, 1, 4, 1);
        vt[15] = mk(0, 0, 1, 16'h21, 1,  1, 1, 16'h20, 1, 4, 1);
        vt[16] = mk(0, 0, 1, 16'h21, 1,  1, 1, 16'h20, 1, 4, 1);
        vt[17] = mk(0, 0, 1, 16'h21, 1,  1, 1, 16'h20, 1, 4, 1);
        vt[18] = mk(0, 0, 1, 16'h21, 1,  1, 1, 16'h20, 1, 4, 1);
        vt[19] = mk(0, 0, 1, 16'h21, 1,  1, 1, 16'h20, 1, 4, 1);
        vt[20] = mk(1, 0, 1, 16'h22, 1,  1, 1, 16'h22, 1, 4, 1);
        vt[21] = mk(0, 1, 1, 16'h23, 1,  0, 1, FV_A,   0, 4, 2);
        vt[22] = mk(1, 0, 0, 16'h00, 1,  0, 1, FV_A,   0, 4, 2);
        // frozen stage does not count stall cycles
        vt[23] = mk(1, 0, 1, 16'h30, 0,  1, 1, 16'h30, 1, 4, 2);
        vt[24] = mk(0, 0, 0, 16'h00, 0,  1, 1, 16'h30, 1, 4, 2);

        drive_a(1, 0, 0, '0, 1);
        step_b = 1'b1; flush_b = 1'b0;
        bus_b.i_valid = 1'b0; bus_b.i_data = '0; bus_b.i_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        chk_a("rst", 0, 1, FV_A, 0, 0, 0);
        chk("b_rst_valid", 32'(bus_b.o_valid), 32'd0);
        chk("b_rst_ready", 32'(bus_b.o_ready), 32'd1);
        chk("b_rst_data",  32'(bus_b.o_data),  32'(FV_B));

        // latch-only instance
        bus_b.i_valid = 1'b1; bus_b.i_data = 16'h40; bus_b.i_ready = 1'b0;
        tick();
        chk("b_fill_data",  32'(bus_b.o_data),  32'h40);
        chk("b_fill_occ",   32'(occ_b),         32'd1);
        chk("b_fill_ready", 32'(bus_b.o_ready), 32'd0);
        bus_b.i_data = 16'h99;
        tick();
        chk("b_block_data",  32'(bus_b.o_data), 32'h40);
        chk("b_block_stall", 32'(stall_b),      32'd1);
        bus_b.i_data = 16'h41; bus_b.i_ready = 1'b1;
        #1;
        chk("b_comb_ready", 32'(bus_b.o_ready), 32'd1);
        tick();
        chk("b_replace_data",  32'(bus_b.o_data),  32'h41);
        chk("b_replace_valid", 32'(bus_b.o_valid), 32'd1);
        chk("b_replace_occ",   32'(occ_b),         32'd1);
        bus_b.i_valid = 1'b0;
        tick();
        chk("b_drain_valid", 32'(bus_b.o_valid), 32'd0);
        chk("b_drain_data",  32'(bus_b.o_data),  32'(FV_B));
        chk("b_drain_occ",   32'(occ_b),         32'd0);
        chk("b_flushcnt",    32'(fcnt_b),        32'd0);

        // table-driven vectors on the skid instance
        for (int i = 0; i < NV; i++) begin
            drive_a(vt[i].step, vt[i].flush, vt[i].valid, vt[i].data, vt[i].ready);
            tick();
            chk_a($sformatf("v%0d", i), vt[i].ev, vt[i].er, vt[i].ed, vt[i].eo, vt[i].es, vt[i].ef);
        end

        // stall counter saturates: starts at 4, 20 stalled cycles
        drive_a(1, 0, 0, '0, 0);
        repeat (20) tick();
        chk("sat_stall", 32'(stall_a), 32'd15);
        chk("sat_data",  32'(bus_a.o_data), 32'h30);

        // one-cycle reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a("midrst", 0, 1, FV_A, 0, 0, 0);

        // flush counter saturates
        for (int i = 0; i < 18; i++) begin
            drive_a(1, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 1);
            tick();
        end
        drive_a(1, 0, 0, '0, 1);
        tick();
        chk_a("sat_flush", 0, 1, FV_A, 0, 0, 15);

        // random traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            drive_a(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 2) != 0));
            tick();
        end
        drive_a(1, 0, 0, '0, 1);
        repeat (4) tick();
        chk("end_q_empty", 32'(exp_q.size()), 32'd0);
        chk("end_valid",   32'(bus_a.o_valid), 32'd0);
        chk("end_data",    32'(bus_a.o_data),  32'(FV_A));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
